alu_issue_sel: RTL and testbench

Parametrised, age-ordered ALU issue selector for the out-of-order core, sitting between the issue queue and the NUM_ALU execution units. Each cycle it picks, per ALU, the oldest issuable ALU-class queue entry that ALU can execute, starting the age scan at the queue head, and registers one-hot issue vectors. Unlike the fixed two-ALU selector it replaces, it handles any ALU count, per-ALU capability masks, multi-cycle occupancy tracking, back-pressure, flush, and suppression of double issue.

---
 rtl/alu_issue_pkg.sv | 9 +
 rtl/age_pick.sv | 29 ++
 rtl/alu_issue_sel.sv | 82 ++++++++
 tb/tb_alu_issue_sel.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: default sizing and shared types for the ALU issue selector.
package alu_issue_pkg;
  localparam int IQ_ENTRIES = 8;
  localparam int NUM_ALU = 2;
  localparam int LAT_W = 4;
  typedef logic [IQ_ENTRIES-1:0] iq_mask_t;
  typedef logic [$clog2(IQ_ENTRIES)-1:0] iq_idx_t;
  typedef logic [LAT_W-1:0] lat_t;
endpackage

// File: rtl/age_pick.sv
// age_pick: rotating-priority first-one finder, oldest request from head not already excluded.
module age_pick import alu_issue_pkg::*; #(
  parameter int N = alu_issue_pkg::IQ_ENTRIES
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] head,
  input  logic [N-1:0]         excl,
  output logic [N-1:0]         gnt
);
  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;
  logic [SW-1:0] sum;
  logic [SW-1:0] idx;
  logic          found;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, head} + SW'(i);
      idx = (sum >= SW'(N)) ? sum - SW'(N) : sum;
      if (!found && req[idx[IW-1:0]] && !excl[idx[IW-1:0]]) begin
        gnt[idx[IW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_issue_sel.sv
// alu_issue_sel: per-ALU oldest-first issue selection with occupancy, stall and flush handling.
module alu_issue_sel import alu_issue_pkg::*; #(
  parameter int IQ_ENTRIES = alu_issue_pkg::IQ_ENTRIES,
  parameter int NUM_ALU = alu_issue_pkg::NUM_ALU,
  parameter int LAT_W = alu_issue_pkg::LAT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          flush,
  input  logic [$clog2(IQ_ENTRIES)-1:0] head,
  input  logic [IQ_ENTRIES-1:0]         could_issue,
  input  logic [IQ_ENTRIES-1:0]         iq_alu,
  input  logic [IQ_ENTRIES-1:0]         iq_prior_sync,
  input  logic [NUM_ALU*IQ_ENTRIES-1:0] iq_cap,
  input  logic [IQ_ENTRIES*LAT_W-1:0]   iq_lat,
  input  logic [NUM_ALU-1:0]            alu_stall,
  output logic [NUM_ALU*IQ_ENTRIES-1:0] issue,
  output logic [NUM_ALU-1:0]            issue_v,
  output logic [NUM_ALU-1:0]            alu_idle
);
  logic [NUM_ALU*IQ_ENTRIES-1:0] issue_q, issue_d;
  logic [NUM_ALU*LAT_W-1:0]      busy_q, busy_d;
  logic [IQ_ENTRIES-1:0]         issued_any, elig;
  logic [IQ_ENTRIES-1:0]         excl [NUM_ALU];
  logic [IQ_ENTRIES-1:0]         gnt [NUM_ALU];
  logic [NUM_ALU-1:0][LAT_W-1:0] sel_lat;
  logic [NUM_ALU-1:0]            avail;
  always_comb begin
    issued_any = '0;
    for (int k = 0; k < NUM_ALU; k++) issued_any = issued_any | issue_q[k*IQ_ENTRIES +: IQ_ENTRIES];
  end
  assign elig = could_issue & iq_alu & ~iq_prior_sync & ~issued_any;
  genvar k;
  generate
    for (k = 0; k < NUM_ALU; k++) begin : g_alu
      assign avail[k] = (busy_q[k*LAT_W +: LAT_W] == '0) & ~alu_stall[k];
      if (k == 0) begin : g_first
        assign excl[k] = '0;
      end else begin : g_rest
        assign excl[k] = excl[k-1] | gnt[k-1];
      end
      age_pick #(.N(IQ_ENTRIES)) u_pick (
        .req  (elig & iq_cap[k*IQ_ENTRIES +: IQ_ENTRIES] & {IQ_ENTRIES{avail[k]}}),
        .head (head),
        .excl (excl[k]),
        .gnt  (gnt[k])
      );
    end
  endgenerate
  // A freshly issued ALU loads lat-1 so that lat 0 and 1 both allow back-to-back issue.
  always_comb begin
    issue_d = '0;
    busy_d = '0;
    sel_lat = '0;
    for (int a = 0; a < NUM_ALU; a++) begin
      for (int n = 0; n < IQ_ENTRIES; n++)
        sel_lat[a] = sel_lat[a] | (gnt[a][n] ? iq_lat[n*LAT_W +: LAT_W] : '0);
      issue_d[a*IQ_ENTRIES +: IQ_ENTRIES] = gnt[a];
      busy_d[a*LAT_W +: LAT_W] = (|gnt[a]) ? ((sel_lat[a] == '0) ? '0 : sel_lat[a] - LAT_W'(1))
                                : ((busy_q[a*LAT_W +: LAT_W] == '0) ? '0 : busy_q[a*LAT_W +: LAT_W] - LAT_W'(1));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q <= '0;
      busy_q <= '0;
    end else if (ce) begin
      issue_q <= flush ? '0 : issue_d;
      busy_q <= flush ? '0 : busy_d;
    end
  end
  assign issue = issue_q;
  always_comb begin
    issue_v = '0;
    alu_idle = '0;
    for (int a = 0; a < NUM_ALU; a++) begin
      issue_v[a] = |issue_q[a*IQ_ENTRIES +: IQ_ENTRIES];
      alu_idle[a] = busy_q[a*LAT_W +: LAT_W] == '0;
    end
  end
endmodule

// File: tb/tb_alu_issue_sel.sv
// tb_alu_issue_sel: directed vectors with hand-computed expectations for alu_issue_sel.
module tb_alu_issue_sel;
  logic        clk = 1'b0;
  logic        rst, ce, flush;
  logic [2:0]  head;
  logic [7:0]  could_issue, iq_alu, iq_prior_sync;
  logic [15:0] iq_cap;
  logic [31:0] iq_lat;
  logic [1:0]  alu_stall;
  logic [15:0] issue;
  logic [1:0]  issue_v, alu_idle;
  int checks = 0;
  int failures = 0;

  alu_issue_sel dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .head(head),
    .could_issue(could_issue), .iq_alu(iq_alu), .iq_prior_sync(iq_prior_sync),
    .iq_cap(iq_cap), .iq_lat(iq_lat), .alu_stall(alu_stall),
    .issue(issue), .issue_v(issue_v), .alu_idle(alu_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; flush = 1'b0; head = 3'd0;
    could_issue = '0; iq_alu = 8'hFF; iq_prior_sync = '0;
    iq_cap = 16'hFFFF; iq_lat = 32'h1111_1111; alu_stall = '0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    chk("rst_issue", 32'(issue), 32'h0);
    chk("rst_issue_v", 32'(issue_v), 32'h0);
    chk("rst_idle", 32'(alu_idle), 32'h3);

    head = 3'd5; could_issue = 8'hFF;
    step();
    chk("head5_issue", 32'(issue), 32'h4020);
    chk("head5_issue_v", 32'(issue_v), 32'h3);
    chk("head5_idle", 32'(alu_idle), 32'h3);
    step();
    chk("wrap_issue", 32'(issue), 32'h0180);
    could_issue = '0;
    step();
    chk("drain_issue", 32'(issue), 32'h0);

    head = 3'd0; could_issue = 8'h0C; iq_cap = {8'h04, 8'hFB};
    step();
    chk("cap_issue", 32'(issue), 32'h0408);
    could_issue = '0; iq_cap = 16'hFFFF;
    step();

    iq_lat = 32'h1111_1141; could_issue = 8'h02;
    step();
    chk("lat4_issue", 32'(issue), 32'h0002);
    chk("lat4_idle1", 32'(alu_idle), 32'h2);
    could_issue = 8'h04; alu_stall = 2'b10;
    step();
    chk("lat4_idle2", 32'(alu_idle), 32'h2);
    chk("lat4_hold2", 32'(issue), 32'h0);
    step();
    chk("lat4_idle3", 32'(alu_idle), 32'h2);
    step();
    chk("lat4_idle4", 32'(alu_idle), 32'h3);
    chk("lat4_hold4", 32'(issue), 32'h0);
    step();
    chk("lat4_next", 32'(issue), 32'h0004);
    could_issue = '0; alu_stall = '0;
    step();

    iq_prior_sync = 8'hFF; could_issue = 8'hFF;
    step();
    chk("sync_issue", 32'(issue), 32'h0);
    iq_prior_sync = '0; could_issue = 8'h03; alu_stall = 2'b10;
    step();
    chk("stall_issue", 32'(issue), 32'h0001);
    chk("stall_issue_v", 32'(issue_v), 32'h1);
    could_issue = '0; alu_stall = '0;
    step();

    iq_lat = 32'h1111_1113; could_issue = 8'h01;
    step();
    chk("fl_pre_issue", 32'(issue), 32'h0001);
    chk("fl_pre_idle", 32'(alu_idle), 32'h2);
    could_issue = 8'h06; flush = 1'b1;
    step();
    chk("flush_issue", 32'(issue), 32'h0);
    chk("flush_idle", 32'(alu_idle), 32'h3);
    flush = 1'b0; could_issue = '0;
    step();

    iq_lat = 32'h1111_1115; could_issue = 8'h01;
    step();
    chk("ce_pre_issue", 32'(issue), 32'h0001);
    ce = 1'b0; could_issue = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ce_hold_issue", 32'(issue), 32'h0001);
      chk("ce_hold_idle", 32'(alu_idle), 32'h2);
    end
    ce = 1'b1;
    step(); step(); step();
    chk("ce_resume3_idle", 32'(alu_idle), 32'h2);
    chk("ce_resume3_issue", 32'(issue), 32'h0);
    step();
    chk("ce_resume4_idle", 32'(alu_idle), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
